// File: rtl/turn_signal_ctrl.sv
// Turn-signal lever and hazard-button controller.
// Synchronizes and debounces raw contacts and drives turn/hazard requests.
module turn_signal_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CANCEL_CYCLES   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic lever_l_raw,
    input  logic lever_r_raw,
    input  logic haz_btn_raw,
    output logic lt,
    output logic rt,
    output logic haz,
    output logic conflict
);

    localparam int HW = $clog2(CANCEL_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(CANCEL_CYCLES - 1);
    localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_CANCELLED
    } state_t;

    // Bit 0 = left lever, bit 1 = right lever, bit 2 = hazard button.
    logic [2:0] w_raw;
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_deb;
    logic [7:0] r_cnt [3];
    logic [2:0] w_flip;

    assign w_raw = {haz_btn_raw, lever_r_raw, lever_l_raw};

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < 3; i++) begin
            w_flip[i] = (r_s2[i] != r_deb[i]) && (r_cnt[i] == DEB_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_deb <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    logic w_deb_l;
    logic w_deb_r;
    logic w_haz_rise;

    assign w_deb_l = r_deb[0];
    assign w_deb_r = r_deb[1];
    // Toggle on the same edge the debounced button goes high.
    assign w_haz_rise = w_flip[2] & r_s2[2];

    logic r_haz_state;
    logic r_haz;
    logic r_conflict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_haz_state <= 1'b0;
            r_haz       <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_haz_state <= r_haz_state ^ w_haz_rise;
            r_haz       <= r_haz_state;
            r_conflict  <= w_deb_l & w_deb_r;
        end
    end

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold;
    logic          w_enter;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A hazard toggling on this cycle blocks a lever entry.
    always_comb begin
        w_state_nxt = r_state;
        if (r_haz_state || (w_deb_l && w_deb_r)) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_haz_rise && w_deb_l) begin
                        w_state_nxt = S_LEFT;
                    end else if (!w_haz_rise && w_deb_r) begin
                        w_state_nxt = S_RIGHT;
                    end
                end
                S_LEFT: begin
                    if (!w_deb_l) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_hold == HOLD_MAX) begin
                        w_state_nxt = S_CANCELLED;
                    end
                end
                S_RIGHT: begin
                    if (!w_deb_r) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_hold == HOLD_MAX) begin
                        w_state_nxt = S_CANCELLED;
                    end
                end
                S_CANCELLED: begin
                    if (!w_deb_l && !w_deb_r) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_enter = (w_state_nxt != r_state) &&
                     ((w_state_nxt == S_LEFT) || (w_state_nxt == S_RIGHT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_enter) begin
            r_hold <= '0;
        end else if (((r_state == S_LEFT) || (r_state == S_RIGHT)) &&
                     (r_hold != HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign lt       = (r_state == S_LEFT);
    assign rt       = (r_state == S_RIGHT);
    assign haz      = r_haz;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: directed scenarios then random bouncy inputs,
// every cycle compared against a sample-window / dwell-time reference model.
module tb_turn_signal_ctrl;

    localparam int D = 4;
    localparam int C = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lever_l_raw = 1'b0;
    logic lever_r_raw = 1'b0;
    logic haz_btn_raw = 1'b0;
    logic lt, rt, haz, conflict;

    turn_signal_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .CANCEL_CYCLES  (C)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lever_l_raw(lever_l_raw),
        .lever_r_raw(lever_r_raw),
        .haz_btn_raw(haz_btn_raw),
        .lt         (lt),
        .rt         (rt),
        .haz        (haz),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: raw sample history, accepted levels, lit direction and dwell.
    bit sh [3][D+2];
    bit m_deb [3];
    bit m_hs;
    int m_dir;
    int m_on;
    bit m_spent;
    bit m_lt, m_rt, m_haz, m_cf;

    function automatic void model(bit l, bit r, bit h, bit rs);
        bit raw [3];
        bit nd [3];
        bit rise, both, all1;
        if (rs) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < D + 2; j++) sh[i][j] = 1'b0;
                m_deb[i] = 1'b0;
            end
            m_hs = 0; m_dir = 0; m_on = 0; m_spent = 0;
            m_lt = 0; m_rt = 0; m_haz = 0; m_cf = 0;
            return;
        end
        raw[0] = l; raw[1] = r; raw[2] = h;
        for (int i = 0; i < 3; i++) begin
            for (int j = D + 1; j >= 1; j--) sh[i][j] = sh[i][j-1];
            sh[i][0] = raw[i];
            // Accept a level once D consecutive synchronized samples disagree.
            all1 = 1'b1;
            for (int j = 2; j <= D + 1; j++)
                if (sh[i][j] == m_deb[i]) all1 = 1'b0;
            nd[i] = all1 ? !m_deb[i] : m_deb[i];
        end
        rise = nd[2] && !m_deb[2];
        both = m_deb[0] && m_deb[1];
        m_haz = m_hs;
        m_cf  = both;
        if (m_hs || both) begin
            m_dir = 0;
            m_spent = 0;
        end else if (m_spent) begin
            if (!m_deb[0] && !m_deb[1]) m_spent = 0;
        end else if (m_dir == 0) begin
            if (!rise && m_deb[0]) begin
                m_dir = 1; m_on = 1;
            end else if (!rise && m_deb[1]) begin
                m_dir = 2; m_on = 1;
            end
        end else if (!m_deb[m_dir-1]) begin
            m_dir = 0;
        end else if (m_on == C) begin
            m_dir = 0;
            m_spent = 1;
        end else begin
            m_on++;
        end
        m_hs = m_hs ^ rise;
        for (int i = 0; i < 3; i++) m_deb[i] = nd[i];
        m_lt = (m_dir == 1);
        m_rt = (m_dir == 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit l, input bit r, input bit h, input bit rs);
        lever_l_raw = l;
        lever_r_raw = r;
        haz_btn_raw = h;
        rst = rs;
        model(l, r, h, rs);
        @(posedge clk);
        #1;
        chk("lt", {31'd0, lt}, {31'd0, m_lt});
        chk("rt", {31'd0, rt}, {31'd0, m_rt});
        chk("haz", {31'd0, haz}, {31'd0, m_haz});
        chk("conflict", {31'd0, conflict}, {31'd0, m_cf});
    endtask

    task automatic run(input int n, input bit l, input bit r, input bit h);
        for (int k = 0; k < n; k++) step(l, r, h, 1'b0);
    endtask

    int lt_hi;
    int rt_hi;
    int rl, rr, rh, dl, dr, dh, rs_left;

    initial begin
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_lt", {31'd0, lt}, 32'd0);
        chk("rst_rt", {31'd0, rt}, 32'd0);
        chk("rst_haz", {31'd0, haz}, 32'd0);
        chk("rst_conflict", {31'd0, conflict}, 32'd0);

        // Left lever: lit exactly 6 edges after first sampling, then cancel.
        lt_hi = 0;
        for (int k = 1; k <= 50; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 6) chk("lat_before", {31'd0, lt}, 32'd0);
            if (k == 7) chk("lat_edge6", {31'd0, lt}, 32'd1);
            if (lt === 1'b1) lt_hi++;
        end
        chk("cancel_len", lt_hi, 32'd32);
        chk("cancel_off", {31'd0, lt}, 32'd0);
        run(10, 1'b0, 1'b0, 1'b0);
        run(10, 1'b1, 1'b0, 1'b0);
        chk("repush_lt", {31'd0, lt}, 32'd1);

        // Hazard on while lit, then off with lever still held.
        run(6, 1'b1, 1'b0, 1'b1);
        chk("haz_pre", {31'd0, haz}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("haz_on", {31'd0, haz}, 32'd1);
        chk("haz_on_lt", {31'd0, lt}, 32'd0);
        run(1, 1'b1, 1'b0, 1'b1);
        run(10, 1'b1, 1'b0, 1'b0);
        run(6, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("haz_off", {31'd0, haz}, 32'd0);
        chk("haz_off_lt", {31'd0, lt}, 32'd1);
        run(1, 1'b1, 1'b0, 1'b1);
        run(10, 1'b1, 1'b0, 1'b0);
        run(10, 1'b0, 1'b0, 1'b0);

        // Short right pulse is rejected.
        rt_hi = 0;
        for (int k = 0; k < 13; k++) begin
            step(1'b0, (k < 3), 1'b0, 1'b0);
            if (rt === 1'b1) rt_hi++;
        end
        chk("glitch_rt", rt_hi, 32'd0);

        // Both levers, then drop right.
        run(10, 1'b1, 1'b1, 1'b0);
        chk("both_cf", {31'd0, conflict}, 32'd1);
        chk("both_lt", {31'd0, lt}, 32'd0);
        chk("both_rt", {31'd0, rt}, 32'd0);
        run(10, 1'b1, 1'b0, 1'b0);
        chk("drop_cf", {31'd0, conflict}, 32'd0);
        chk("drop_lt", {31'd0, lt}, 32'd1);
        run(10, 1'b0, 1'b0, 1'b0);

        // Reset while hazard active and dwell counter mid-count.
        run(20, 1'b1, 1'b0, 1'b0);
        run(8, 1'b1, 1'b0, 1'b1);
        run(2, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_haz", {31'd0, haz}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_lt", {31'd0, lt}, 32'd0);
        chk("mid_rst_haz", {31'd0, haz}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        run(20, 1'b0, 1'b0, 1'b0);
        chk("post_rst_haz", {31'd0, haz}, 32'd0);

        // Random bouncy inputs with occasional reset.
        rl = 0; rr = 0; rh = 0; dl = 0; dr = 0; dh = 0; rs_left = 0;
        for (int k = 0; k < 4000; k++) begin
            if (dl == 0) begin
                rl = $urandom_range(0, 1);
                dl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                 : $urandom_range(5, 60);
            end
            if (dr == 0) begin
                rr = ($urandom_range(0, 2) == 0);
                dr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                 : $urandom_range(5, 60);
            end
            if (dh == 0) begin
                rh = ($urandom_range(0, 3) == 0);
                dh = $urandom_range(1, 12);
            end
            if (rs_left == 0 && $urandom_range(0, 799) == 0)
                rs_left = $urandom_range(1, 3);
            step(rl[0], rr[0], rh[0], (rs_left != 0));
            dl--; dr--; dh--;
            if (rs_left != 0) rs_left--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
